// File: rtl/uart_tx_fifo.sv
// UART transmitter with a built-in transmit FIFO, running on the 16x oversample clock.
// Define UART_TX_PARITY_EN to add a parity bit (odd when PARITY_ODD = 1) after the data bits.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVS        = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                            clk16,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            serial_data,
    output logic                            tx_busy,
    output logic                            tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(OVS);
    localparam int unsigned BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] BIT_PRE   = CNT_W'(OVS - 2);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [BIT_W-1:0]   data_cnt_q;
    logic               stop_cnt_q;
    logic [DATA_W-1:0]  shift_q;

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   level_q;

    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               bit_end;
    logic               last_stop;
    logic [DATA_W-1:0]  head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign tx_ready   = !fifo_full;
    assign fifo_level = level_q;
    assign push       = tx_valid && tx_ready;
    assign head       = mem_q[rd_ptr_q];
    assign bit_end    = (bit_cnt_q == BIT_LAST);
    assign last_stop  = (state_q == StStop) && (stop_cnt_q == STOP_LAST);

    // Pop either from idle or on the final cycle of a frame so the next start bit follows at once.
    assign pop = !fifo_empty && ((state_q == StIdle) || (last_stop && bit_end));

    always_ff @(posedge clk16) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_INV = (PARITY_ODD != 0);
    logic parity_q;

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= (^head) ^ PAR_INV;
        end
    end
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            data_cnt_q  <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            serial_data <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state_q != StIdle) begin
                bit_cnt_q <= bit_end ? '0 : bit_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q     <= head;
                        state_q     <= StStart;
                        serial_data <= 1'b0;
                        tx_busy     <= 1'b1;
                    end else begin
                        serial_data <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q     <= StData;
                        serial_data <= shift_q[0];
                        shift_q     <= shift_q >> 1;
                        data_cnt_q  <= '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (data_cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_q     <= StParity;
                            serial_data <= parity_q;
`else
                            state_q     <= StStop;
                            serial_data <= 1'b1;
                            stop_cnt_q  <= 1'b0;
`endif
                        end else begin
                            data_cnt_q  <= data_cnt_q + BIT_W'(1);
                            serial_data <= shift_q[0];
                            shift_q     <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        state_q     <= StStop;
                        serial_data <= 1'b1;
                        stop_cnt_q  <= 1'b0;
                    end
                end
`endif
                StStop: begin
                    // Registered pulse lands on the last cycle of the final stop bit.
                    if (last_stop && (bit_cnt_q == BIT_PRE)) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (last_stop) begin
                            if (pop) begin
                                shift_q     <= head;
                                state_q     <= StStart;
                                serial_data <= 1'b0;
                            end else begin
                                state_q     <= StIdle;
                                serial_data <= 1'b1;
                                tx_busy     <= 1'b0;
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    serial_data <= 1'b1;
                    tx_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: an 8-bit/OVS16 instance and a 5-bit/OVS8/2-stop
// instance share clock and reset.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int OVS  = 16;
    localparam int FL   = OVS * (10 + P);
    localparam int OVS5 = 8;
    localparam int FL5  = OVS5 * (8 + P);

    logic       clk16 = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_data;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_level;

    logic [4:0] tx_data5;
    logic       tx_valid5;
    logic       tx_ready5;
    logic       serial5;
    logic       busy5;
    logic       done5;
    logic [2:0] level5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk16 = ~clk16;

    uart_tx_fifo #(
        .DATA_W(8), .OVS(16), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_dut (
        .clk16(clk16), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .serial_data(serial_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .fifo_level(fifo_level)
    );

    uart_tx_fifo #(
        .DATA_W(5), .OVS(8), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_dut5 (
        .clk16(clk16), .rst_n(rst_n), .tx_data(tx_data5), .tx_valid(tx_valid5),
        .tx_ready(tx_ready5), .serial_data(serial5), .tx_busy(busy5),
        .tx_done(done5), .fifo_level(level5)
    );

    // Drives one word so that it is accepted at the next rising edge; returns #1 after that edge.
    task automatic push_word(input logic [7:0] d);
        @(negedge clk16);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk16);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Receives one frame from the main instance; gap counts idle cycles before the start bit.
    task automatic rx_word(output logic [7:0] data, output logic par, output bit ok,
                           output int gap);
        int b;
        data = '0;
        par  = 1'b0;
        ok   = 1'b1;
        gap  = 0;
        @(posedge clk16);
        #1;
        while (serial_data !== 1'b0 && gap < 4 * FL) begin
            gap++;
            @(posedge clk16);
            #1;
        end
        if (serial_data !== 1'b0) begin
            ok  = 1'b0;
            gap = -1;
            return;
        end
        for (int c = 1; c <= FL; c++) begin
            if (c > 1) begin
                @(posedge clk16);
                #1;
            end
            b = (c - 1) / OVS;
            if (b == 0) begin
                if (serial_data !== 1'b0) ok = 1'b0;
            end else if (b <= 8) begin
                if ((c - 1) % OVS == OVS / 2) data[b-1] = serial_data;
            end else if (b < 9 + P) begin
                if ((c - 1) % OVS == OVS / 2) par = serial_data;
            end else if (serial_data !== 1'b1) begin
                ok = 1'b0;
            end
            if (tx_done !== (c == FL)) ok = 1'b0;
            if (tx_busy !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_valid5 = 1'b0;
        tx_data5  = 5'h00;
        #12;
        n_checks += 6;
        if (serial_data !== 1'b1) begin n_fail++; $display("FAIL reset serial_data: got %b want 1", serial_data); end
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset tx_busy: got %b want 0", tx_busy); end
        if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset tx_done: got %b want 0", tx_done); end
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset fifo_level: got %0d want 0", fifo_level); end
        if (serial5 !== 1'b1) begin n_fail++; $display("FAIL reset serial5: got %b want 1", serial5); end
        @(negedge clk16);
        rst_n = 1'b1;
        @(posedge clk16);
        #1;
        n_checks++;
        if (serial_data !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post-reset idle: got serial=%b busy=%b want 1/0", serial_data, tx_busy);
        end
    endtask

    task automatic test_single();
        logic [15:0] exp_bits;
`ifdef UART_TX_PARITY_EN
        exp_bits = 16'b0000_0101_0100_1010;
`else
        exp_bits = 16'b0000_0011_0100_1010;
`endif
        push_word(8'hA5);
        n_checks += 2;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single level after push: got %0d want 1", fifo_level); end
        if (serial_data !== 1'b1) begin n_fail++; $display("FAIL single line before start: got %b want 1", serial_data); end
        for (int c = 1; c <= FL; c++) begin
            @(posedge clk16);
            #1;
            n_checks += 3;
            if (serial_data !== exp_bits[(c-1)/OVS]) begin
                n_fail++;
                $display("FAIL single bit cycle %0d: got %b want %b", c, serial_data, exp_bits[(c-1)/OVS]);
            end
            if (tx_done !== (c == FL)) begin
                n_fail++;
                $display("FAIL single tx_done cycle %0d: got %b want %b", c, tx_done, (c == FL));
            end
            if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single busy cycle %0d: got %b want 1", c, tx_busy); end
        end
        @(posedge clk16);
        #1;
        n_checks++;
        if (tx_busy !== 1'b0 || serial_data !== 1'b1 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single end: got busy=%b line=%b done=%b want 0/1/0", tx_busy, serial_data, tx_done);
        end
    endtask

    task automatic test_data5();
        logic [15:0] exp_bits;
`ifdef UART_TX_PARITY_EN
        exp_bits = 16'b0000_0001_1110_0110;
`else
        exp_bits = 16'b0000_0000_1110_0110;
`endif
        @(negedge clk16);
        tx_data5  = 5'h13;
        tx_valid5 = 1'b1;
        @(posedge clk16);
        #1;
        tx_valid5 = 1'b0;
        tx_data5  = 5'h00;
        for (int c = 1; c <= FL5; c++) begin
            @(posedge clk16);
            #1;
            n_checks += 2;
            if (serial5 !== exp_bits[(c-1)/OVS5]) begin
                n_fail++;
                $display("FAIL data5 bit cycle %0d: got %b want %b", c, serial5, exp_bits[(c-1)/OVS5]);
            end
            if (done5 !== (c == FL5)) begin
                n_fail++;
                $display("FAIL data5 tx_done cycle %0d: got %b want %b", c, done5, (c == FL5));
            end
        end
        @(posedge clk16);
        #1;
        n_checks++;
        if (busy5 !== 1'b0 || serial5 !== 1'b1) begin
            n_fail++;
            $display("FAIL data5 end: got busy=%b line=%b want 0/1", busy5, serial5);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        logic       p;
        bit         ok;
        int         gap;
        push_word(8'hA5);
        rx_word(d, p, ok, gap);
        n_checks += 3;
        if (d !== 8'hA5 || gap != 0) begin n_fail++; $display("FAIL parity A5 data: got %h gap %0d want a5 gap 0", d, gap); end
        if (p !== 1'b0) begin n_fail++; $display("FAIL parity A5 bit: got %b want 0", p); end
        if (!ok) begin n_fail++; $display("FAIL parity A5 framing: got bad frame want 176-cycle frame"); end
        push_word(8'h07);
        rx_word(d, p, ok, gap);
        n_checks += 3;
        if (d !== 8'h07 || gap != 0) begin n_fail++; $display("FAIL parity 07 data: got %h gap %0d want 07 gap 0", d, gap); end
        if (p !== 1'b1) begin n_fail++; $display("FAIL parity 07 bit: got %b want 1", p); end
        if (!ok) begin n_fail++; $display("FAIL parity 07 framing: got bad frame want 176-cycle frame"); end
        @(posedge clk16);
        #1;
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] w [6];
        int         exp_edge [6];
        logic [2:0] exp_lvl [6];
        int         acc_edge [6];
        logic [2:0] acc_lvl [6];
        logic       ready_after5;
        logic       acc;
        int         edge_n;
        int         i;
        logic [7:0] d;
        logic       p;
        bit         ok;
        int         gap;
        w        = '{8'h11, 8'h22, 8'h3C, 8'h5A, 8'h96, 8'hF0};
        exp_edge = '{1, 2, 3, 4, 5, 3 + FL};
        exp_lvl  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        ready_after5 = 1'bx;
        fork
            begin : pusher
                edge_n = 0;
                i      = 0;
                while (i < 6 && edge_n < 3 * FL) begin
                    @(negedge clk16);
                    tx_data  = w[i];
                    tx_valid = 1'b1;
                    acc      = tx_ready;
                    @(posedge clk16);
                    edge_n++;
                    #1;
                    if (acc) begin
                        acc_edge[i] = edge_n;
                        acc_lvl[i]  = fifo_level;
                        i++;
                        if (i == 5) ready_after5 = tx_ready;
                    end
                end
                tx_valid = 1'b0;
                n_checks++;
                if (i != 6) begin n_fail++; $display("FAIL b2b accepted count: got %0d want 6", i); end
                n_checks++;
                if (ready_after5 !== 1'b0) begin n_fail++; $display("FAIL b2b tx_ready after 5: got %b want 0", ready_after5); end
                for (int k = 0; k < i; k++) begin
                    n_checks += 2;
                    if (acc_edge[k] != exp_edge[k]) begin
                        n_fail++;
                        $display("FAIL b2b accept edge %0d: got %0d want %0d", k, acc_edge[k], exp_edge[k]);
                    end
                    if (acc_lvl[k] !== exp_lvl[k]) begin
                        n_fail++;
                        $display("FAIL b2b level %0d: got %0d want %0d", k, acc_lvl[k], exp_lvl[k]);
                    end
                end
            end
            begin : receiver
                for (int k = 0; k < 6; k++) begin
                    rx_word(d, p, ok, gap);
                    n_checks += 2;
                    if (d !== w[k] || !ok) begin
                        n_fail++;
                        $display("FAIL b2b frame %0d: got %h ok=%0d want %h ok=1", k, d, ok, w[k]);
                    end
                    if (gap != ((k == 0) ? 1 : 0)) begin
                        n_fail++;
                        $display("FAIL b2b gap %0d: got %0d want %0d", k, gap, (k == 0) ? 1 : 0);
                    end
                end
                @(posedge clk16);
                #1;
                n_checks++;
                if (serial_data !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) begin
                    n_fail++;
                    $display("FAIL b2b end: got line=%b busy=%b level=%0d want 1/0/0", serial_data, tx_busy, fifo_level);
                end
            end
        join
    endtask

    task automatic test_full_drop();
        logic [7:0] w [5];
        logic [7:0] d;
        logic       p;
        bit         ok;
        int         gap;
        int         bad;
        w = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3};
        fork
            begin : pusher
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk16);
                    tx_data  = w[k];
                    tx_valid = 1'b1;
                    @(posedge clk16);
                end
                @(negedge clk16);
                tx_data = 8'hEE;
                n_checks++;
                if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL drop tx_ready when full: got %b want 0", tx_ready); end
                @(posedge clk16);
                #1;
                tx_valid = 1'b0;
                tx_data  = 8'h00;
                n_checks++;
                if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL drop level: got %0d want 4", fifo_level); end
            end
            begin : receiver
                for (int k = 0; k < 5; k++) begin
                    rx_word(d, p, ok, gap);
                    n_checks++;
                    if (d !== w[k] || !ok || gap != ((k == 0) ? 1 : 0)) begin
                        n_fail++;
                        $display("FAIL drop frame %0d: got %h ok=%0d gap=%0d want %h", k, d, ok, gap, w[k]);
                    end
                end
                bad = 0;
                for (int c = 0; c < 2 * FL; c++) begin
                    @(posedge clk16);
                    #1;
                    if (serial_data !== 1'b1 || tx_busy !== 1'b0) bad++;
                end
                n_checks++;
                if (bad != 0) begin n_fail++; $display("FAIL drop idle after: got %0d active cycles want 0", bad); end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        push_word(8'h55);
        push_word(8'h66);
        push_word(8'h77);
        repeat (40) @(posedge clk16);
        n_checks++;
        if (tx_busy !== 1'b1 || fifo_level !== 3'd2) begin
            n_fail++;
            $display("FAIL midreset precondition: got busy=%b level=%0d want 1/2", tx_busy, fifo_level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (serial_data !== 1'b1) begin n_fail++; $display("FAIL midreset line: got %b want 1", serial_data); end
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midreset level: got %0d want 0", fifo_level); end
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", tx_busy); end
        if (tx_done !== 1'b0) begin n_fail++; $display("FAIL midreset done: got %b want 0", tx_done); end
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midreset ready: got %b want 1", tx_ready); end
        @(negedge clk16);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 2 * FL; c++) begin
            @(posedge clk16);
            #1;
            if (serial_data !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_level !== 3'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL midreset idle after: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_data5();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_full_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
